mc_control_unit: RTL
====================

# mc_control_unit

Parametrised multi-cycle control FSM, the successor to the core's four-state control unit. It sequences fetch, execute and wait phases for loads, stores and up to NUM_MC_UNITS multi-cycle ALU units, such as a divider or multiplier. It adds a wait-timeout trap, a debug halt and retire/cycle counters. It sits between the decode stage, the i/d-cache interfaces and the multi-cycle execution units.

## Interface
- NUM_MC_UNITS, 2, number of multi-cycle execution units (≥1)
- TIMEOUT_CYCLES, 256, wait cycles before trap; 0 disables timeout
- CNT_W, 32, width of cycle/instret counters
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- isLoad / isStore  in  1  decoded current instruction is load / store
- mc_sel  in  NUM_MC_UNITS  one-hot multi-cycle unit used by current instruction; all-zero = single-cycle op
- unit_busy  in  NUM_MC_UNITS  per-unit busy
- icache_ready / dcache_ready  in  1  cache completion
- halt_req  in  1  debug halt request (level)
- trap_ack  in  1  clears timeout trap
- pc_load_en  out  1  PC update strobe
- alu_op_valid  out  NUM_MC_UNITS  per-unit start strobe
- writeBack_en  out  1  registered register-file write strobe
- icache_req, dcache_ren, dcache_wen  out  1  cache requests
- timeout_trap  out  1  high while in TRAP
- halted  out  1  high while in HALT
- state_out  out  7  one-hot state
- cycle_cnt, instret_cnt  out  CNT_W  free-running counters

## Operation
- One-hot states: FETCH(bit0), WAIT_INSTR(1), EXECUTE(2), WAIT_MEM(3), WAIT_ALU(4), TRAP(5), HALT(6).
- Reset (async, reset=0): state=FETCH, writeBack_en=0, counters=0, wait_cnt=0. All combinational outputs follow from FETCH: icache_req=!halt_req, all others 0.
- mem = isLoad|isStore. If both isLoad and isStore are set, the instruction is treated as a load. mem has priority over mc_sel; mc_sel is ignored when mem=1.
- FETCH: if halt_req → HALT, and icache_req is suppressed. Otherwise icache_req=1 → WAIT_INSTR.
- WAIT_INSTR: icache_ready → EXECUTE.
- EXECUTE (always 1 cycle):
  - pc_load_en=1.
  - dcache_ren=isLoad; dcache_wen=isStore&!isLoad.
  - alu_op_valid=mc_sel when !mem.
  - Next state: mem → WAIT_MEM; else mc_sel≠0 → WAIT_ALU; else → FETCH (retire).
- WAIT_MEM: dcache_ready → FETCH (retire).
- WAIT_ALU: (mc_sel & ~unit_busy)≠0 → FETCH (retire). Units must assert busy on the same edge that samples alu_op_valid.
- Timeout:
  - wait_cnt clears on entry to any wait state and increments on each wait cycle without completion.
  - If TIMEOUT_CYCLES≠0 and wait_cnt==TIMEOUT_CYCLES-1 with no completion that cycle → TRAP.
  - Completion in the limit cycle wins over the trap.
- TRAP: timeout_trap=1, no strobes. trap_ack → FETCH. PC is unchanged, so the same instruction is refetched.
- HALT: halted=1. Exits to FETCH when halt_req=0. halt_req is sampled only in FETCH; in-flight instructions complete first.
- writeBack_en (registered) is set on the edge leaving:
  - EXECUTE on retire;
  - WAIT_MEM with isLoad&dcache_ready;
  - WAIT_ALU on completion.
  It is 0 otherwise, and 0 for stores and for trap exits.
- instret_cnt +1 on every retire edge (the three FETCH-bound transitions above, stores included). It is never incremented on a TRAP exit.
- cycle_cnt +1 every cycle not in HALT. Both counters wrap modulo 2^CNT_W.
- Illegal/no-hot state → FETCH next cycle.

## Timing
- Single-cycle op with icache_ready in the first WAIT_INSTR cycle: 3 cycles/instruction. writeBack_en is high in the first cycle of the next FETCH.
- Load: EXECUTE, then ≥1 WAIT_MEM cycle. writeBack_en is high the cycle after the WAIT_MEM cycle that saw dcache_ready.
- Strobes (pc_load_en, alu_op_valid, dcache_ren/wen) are single-cycle pulses during EXECUTE only.
- Counters and writeBack_en update on the same edge as the state transition.
- Reset assertion mid-wait immediately forces FETCH and clears writeBack_en without a clock edge.

## Test plan
- Reset release, icache_ready held 1, ALU op (mc_sel=0) → state sequence 1,2,4,1; writeBack_en pulse at cycle 4; instret_cnt=1.
- Load, dcache_ready after 3 wait cycles → 3 cycles with state_out=8, then writeBack_en=1 for 1 cycle. Store with same timing → writeBack_en stays 0, instret_cnt still +1.
- mc_sel=2'b10, unit_busy[1] high 5 cycles → alu_op_valid=2'b10 in EXECUTE, WAIT_ALU for 5 cycles, retire on cycle 6, writeBack_en pulse.
- TIMEOUT_CYCLES=4, dcache_ready never → TRAP after exactly 4 WAIT_MEM cycles, timeout_trap=1; trap_ack → FETCH, pc_load_en not re-pulsed, instret unchanged. Variant with dcache_ready in the 4th cycle → normal retire.
- halt_req asserted during WAIT_ALU → instruction retires, then HALT without icache_req; cycle_cnt frozen; deassert → fetch resumes.
- Async reset pulse mid-WAIT_MEM (no clock edge) → state_out=1, writeBack_en=0, counters=0 immediately.

Source files
------------

// File: rtl/mc_control_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : mc_control_unit
// Brief    : Multi-cycle control FSM: fetch/execute/wait sequencing with
//            wait-timeout trap, debug halt and retire/cycle counters.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module mc_control_unit #(
  parameter int NUM_MC_UNITS   = 2,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    isLoad,
  input  logic                    isStore,
  input  logic [NUM_MC_UNITS-1:0] mc_sel,
  input  logic [NUM_MC_UNITS-1:0] unit_busy,
  input  logic                    icache_ready,
  input  logic                    dcache_ready,
  input  logic                    halt_req,
  input  logic                    trap_ack,
  output logic                    pc_load_en,
  output logic [NUM_MC_UNITS-1:0] alu_op_valid,
  output logic                    writeBack_en,
  output logic                    icache_req,
  output logic                    dcache_ren,
  output logic                    dcache_wen,
  output logic                    timeout_trap,
  output logic                    halted,
  output logic [6:0]              state_out,
  output logic [CNT_W-1:0]        cycle_cnt,
  output logic [CNT_W-1:0]        instret_cnt
);

  typedef enum logic [6:0] {
    S_FETCH      = 7'b0000001,
    S_WAIT_INSTR = 7'b0000010,
    S_EXECUTE    = 7'b0000100,
    S_WAIT_MEM   = 7'b0001000,
    S_WAIT_ALU   = 7'b0010000,
    S_TRAP       = 7'b0100000,
    S_HALT       = 7'b1000000
  } state_t;

  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] c_WAIT_LIMIT =
    WAIT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam bit c_TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  state_t            r_state;
  logic [WAIT_W-1:0] r_wait_cnt;

  logic w_mem;
  logic w_in_wait;
  logic w_done;
  logic w_timeout;

  assign w_mem     = isLoad | isStore;
  assign w_in_wait = (r_state == S_WAIT_INSTR) || (r_state == S_WAIT_MEM) ||
                     (r_state == S_WAIT_ALU);

  always_comb begin
    w_done = 1'b0;
    case (r_state)
      S_WAIT_INSTR: w_done = icache_ready;
      S_WAIT_MEM:   w_done = dcache_ready;
      S_WAIT_ALU:   w_done = |(mc_sel & ~unit_busy);
      default:      w_done = 1'b0;
    endcase
  end

  // A completion arriving in the limit cycle takes precedence over the trap.
  assign w_timeout = c_TIMEOUT_EN && w_in_wait && !w_done &&
                     (r_wait_cnt == c_WAIT_LIMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_FETCH;
      r_wait_cnt   <= '0;
      writeBack_en <= 1'b0;
      cycle_cnt    <= '0;
      instret_cnt  <= '0;
    end else begin
      writeBack_en <= 1'b0;
      if (r_state != S_HALT) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (w_in_wait && !w_done) r_wait_cnt <= r_wait_cnt + WAIT_W'(1);

      case (r_state)
        S_FETCH: begin
          if (halt_req) begin
            r_state <= S_HALT;
          end else begin
            r_state    <= S_WAIT_INSTR;
            r_wait_cnt <= '0;
          end
        end
        S_WAIT_INSTR: begin
          if (icache_ready)   r_state <= S_EXECUTE;
          else if (w_timeout) r_state <= S_TRAP;
        end
        S_EXECUTE: begin
          if (w_mem) begin
            r_state    <= S_WAIT_MEM;
            r_wait_cnt <= '0;
          end else if (|mc_sel) begin
            r_state    <= S_WAIT_ALU;
            r_wait_cnt <= '0;
          end else begin
            r_state      <= S_FETCH;
            writeBack_en <= 1'b1;
            instret_cnt  <= instret_cnt + CNT_W'(1);
          end
        end
        S_WAIT_MEM: begin
          if (dcache_ready) begin
            r_state      <= S_FETCH;
            writeBack_en <= isLoad;
            instret_cnt  <= instret_cnt + CNT_W'(1);
          end else if (w_timeout) begin
            r_state <= S_TRAP;
          end
        end
        S_WAIT_ALU: begin
          if (w_done) begin
            r_state      <= S_FETCH;
            writeBack_en <= 1'b1;
            instret_cnt  <= instret_cnt + CNT_W'(1);
          end else if (w_timeout) begin
            r_state <= S_TRAP;
          end
        end
        S_TRAP: begin
          if (trap_ack) r_state <= S_FETCH;
        end
        S_HALT: begin
          if (!halt_req) r_state <= S_FETCH;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Strobes are decoded from the registered state; decode inputs qualify them.
  assign state_out    = r_state;
  assign icache_req   = (r_state == S_FETCH) && !halt_req;
  assign pc_load_en   = (r_state == S_EXECUTE);
  assign dcache_ren   = pc_load_en && isLoad;
  assign dcache_wen   = pc_load_en && isStore && !isLoad;
  assign alu_op_valid = (pc_load_en && !w_mem) ? mc_sel : '0;
  assign timeout_trap = (r_state == S_TRAP);
  assign halted       = (r_state == S_HALT);

endmodule
`default_nettype wire
